// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch/timer control stage and the BCD counters.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DOWN_COUNT = 1'b0;
    localparam logic UP_COUNT   = 1'b1;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a debounced button level; one pulse per press.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    // History resets high so a button held through reset yields no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch/timer control: button edges, run/pause/done FSM, tick divider, terminal detect.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int TOP_TENS = 5,
    parameter int TOP_ONES = 9,
    parameter int DIV_W    = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_mode,
    input  logic       btn_clear,
    input  logic [3:0] digit_tens,
    input  logic [3:0] digit_ones,
    output logic       tick,
    output logic       en,
    output logic       clr,
    output logic       mode_select,
    output logic       zero,
    output logic       top,
    output logic       done
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       TENS_TOP = 4'(TOP_TENS);
    localparam logic [3:0]       ONES_TOP = 4'(TOP_ONES);

    logic             start_edge;
    logic             mode_edge;
    logic             clear_edge;
    logic             terminal;
    logic             mode_next;
    logic             clr_next;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    state_t           state;
    state_t           state_next;

    edge_pulse u_start (.clk(clk), .rst(rst), .level(btn_start_stop), .pulse(start_edge));
    edge_pulse u_mode  (.clk(clk), .rst(rst), .level(btn_mode),       .pulse(mode_edge));
    edge_pulse u_clear (.clk(clk), .rst(rst), .level(btn_clear),      .pulse(clear_edge));

    assign zero     = (mode_select == DOWN_COUNT) && (digit_tens == 4'd0) && (digit_ones == 4'd0);
    assign top      = (mode_select == UP_COUNT) && (digit_tens == TENS_TOP) && (digit_ones == ONES_TOP);
    assign terminal = zero | top;

    assign en   = (state == RUN);
    assign done = (state == DONE);
    assign tick = (state == RUN) && !terminal && (div == DIV_LAST);

    always_comb begin
        state_next = state;
        mode_next  = mode_select;
        clr_next   = 1'b0;
        if (clear_edge) begin
            state_next = IDLE;
            clr_next   = 1'b1;
        end else if (mode_edge && (state == IDLE)) begin
            mode_next = ~mode_select;
            clr_next  = 1'b1;
        end else if (start_edge) begin
            case (state)
                IDLE, PAUSE: state_next = RUN;
                RUN:         state_next = PAUSE;
                default:     state_next = state;
            endcase
        end else if ((state == RUN) && terminal) begin
            state_next = DONE;
        end
    end

    // The cycle in which a pause edge lands is still a RUN cycle, so it advances
    // the divider; the resume cycle is a PAUSE cycle and only holds it.
    always_comb begin
        div_next = '0;
        if (state_next inside {RUN, PAUSE}) begin
            if (state == RUN) begin
                div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            end else if (state == PAUSE) begin
                div_next = div;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_select <= DOWN_COUNT;
            div         <= '0;
            clr         <= 1'b0;
        end else begin
            state       <= state_next;
            mode_select <= mode_next;
            div         <= div_next;
            clr         <= clr_next;
        end
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control stage directly upstream of the BCD digit counters in the lab06 stopwatch/timer.
- Turns debounced pushbutton levels into the counters' control inputs: en, increase/decrease tick, counter clear, mode_select.
- Uses the seconds digits the counters produce to detect terminal count (zero/top) and to stop the run.
- Holds the run/pause/done state machine and the 1 Hz tick divider.

Parameters:
- TICK_DIV, 100000000, clk cycles per count tick (1 Hz at 100 MHz); minimum 2.
- TOP_TENS, 5, tens digit of the up-count terminal value.
- TOP_ONES, 9, ones digit of the up-count terminal value.
- DIV_W, 27, divider width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_start_stop  in  1  debounced level; rising edge toggles run/pause.
- btn_mode  in  1  debounced level; rising edge toggles count direction (IDLE only).
- btn_clear  in  1  debounced level; rising edge returns to IDLE and clears counters.
- digit_tens  in  4  current tens digit from the counter chain.
- digit_ones  in  4  current ones digit from the counter chain.
- tick  out  1  one-cycle pulse to the counters' increase/decrease inputs.
- en  out  1  counter enable; high only in RUN.
- clr  out  1  one-cycle counter clear pulse (drives the counters' rst).
- mode_select  out  1  0 = down count, 1 = up count.
- zero  out  1  down mode and both digits == 0.
- top  out  1  up mode and digits == TOP_TENS:TOP_ONES.
- done  out  1  high in DONE (LED).

Behaviour:
- Reset is synchronous, active-high; one clock, all state on posedge clk.
- Reset values: state = IDLE, mode_select = 0, divider = 0, tick = 0, clr = 0, done = 0. Button history registers reset to 1, so a button held through reset gives no edge.
- Edge detect: edge = btn & ~btn_prev, with btn_prev registered each cycle. An action occurs once per press.
- zero, top and terminal (= zero | top) are combinational from the digits and mode_select.
- FSM states: IDLE, RUN, PAUSE, DONE. Priority per cycle is clear > mode > start_stop > terminal.
  - Clear edge, any state: go to IDLE; clr = 1 next cycle for exactly 1 cycle; divider = 0.
  - Mode edge in IDLE: toggle mode_select; clr pulse next cycle, so counters load the new mode's initial value. Ignored in RUN, PAUSE and DONE.
  - Start/stop edge: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. Ignored in DONE.
  - RUN with terminal true: go to DONE in the same cycle; tick is suppressed that cycle.
- Divider:
  - Counts only in RUN.
  - Holds its value in PAUSE, preserving the partial second.
  - Cleared in IDLE and DONE.
  - At TICK_DIV-1 it wraps to 0 and tick = 1 for that cycle, registered. The first tick comes TICK_DIV cycles after entering RUN from IDLE.
- en = (state == RUN). done = (state == DONE).
- A tick is never asserted outside RUN, never when terminal, and never in a clr cycle.
- Start pressed with terminal already true (e.g. down mode at 00): enters RUN, then DONE the next cycle, with no tick.
- Start and clear edges in the same cycle: clear wins; state = IDLE.

Decomposition:
- Shared package timer_pkg:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  - DOWN_COUNT = 0, UP_COUNT = 1, shared with the BCD counters.
- One sub-module, edge_pulse: registered rising-edge detector, instantiated three times.
- The divider and FSM stay in timer_ctrl.

Test Plan (TICK_DIV = 4):
- Reset, then start edge with digits 3:0 in down mode -> en = 1 from the next cycle; tick every 4 cycles, first on the 4th RUN cycle; no clr.
- In RUN, drive digits to 0:0 -> zero = 1; state DONE the same cycle; en = 0, done = 1, no further ticks; start edge ignored.
- Start, run 2 cycles, start (pause), wait 10 cycles, start -> next tick after exactly 2 more RUN cycles (divider held).
- In IDLE, mode edge -> mode_select = 1 and clr = 1 for exactly 1 cycle. Mode edge while in RUN -> no change.
- Up mode with digits 5:9 in RUN -> top = 1, DONE. Clear edge -> IDLE, clr pulse, done = 0, divider 0.
- Hold btn_start_stop = 1 through rst, then release -> no state change. Start and clear edges in the same cycle -> IDLE plus clr.
